// File: rtl/vector_cache_pkg.sv
// Shared vector-cache definitions used by the SRAM access path.
//   sram_inst_cmd_t : command word presented to sram_inst (addr, byte_sel, mode)
//   sram_rsp_t      : read response record (data + requester tag)
package vector_cache_pkg;

  localparam int SRAM_INST_ADDR_W = 9;
  localparam int SRAM_INST_DATA_W = 32;
  localparam int SRAM_RSP_TAG_W   = 4;

  typedef struct packed {
    logic [SRAM_INST_ADDR_W-1:0] addr;
    logic [1:0]                  byte_sel;
    logic                        mode;
  } sram_inst_cmd_t;

  typedef struct packed {
    logic [SRAM_INST_DATA_W-1:0] data;
    logic [SRAM_RSP_TAG_W-1:0]   tag;
  } sram_rsp_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous FIFO with registered storage and a combinational head.
// DEPTH must be a power of two (pointers wrap naturally).
// Ports:
//   clk, rst          clock, synchronous active-high reset (empties the FIFO)
//   push_i/push_data_i write one entry
//   pop_i             remove the head entry (ignored when empty)
//   pop_data_o        current head entry
//   cnt_o             number of stored entries (0..DEPTH)
//   full_o, empty_o   occupancy flags
module sram_rsp_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               pop_data_o,
  output logic [$clog2(DEPTH):0]     cnt_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;

  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push_i && full_o && !do_pop));
    end
  end

endmodule

// File: rtl/sram_rw_arb.sv
// Single-port access controller in front of one sram_inst.
// Arbitrates a write-request and a read-request channel onto the SRAM command
// ports (never both in one cycle), captures the 1-cycle-latency read data with
// its tag into a response FIFO and returns it over a valid/ready channel.
// Outstanding reads are bounded by FIFO space (credit).
// Optional feature: define SRAM_RW_ARB_PERF_EN to enable the perf counters;
// otherwise perf_conflict_cnt/perf_stall_cnt are tied to 0.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   wr_req_vld/rdy/cmd/data          write request channel
//   rd_req_vld/rdy/cmd/tag           read request channel
//   rsp_vld/rdy/data/tag             read response channel
//   sram_read_vld/cmd                to sram_inst read port
//   sram_write_vld/cmd, sram_wr_data to sram_inst write port
//   sram_rd_data                     from sram_inst, valid 1 cycle after a read
//   perf_conflict_cnt                cycles with both requests valid
//   perf_stall_cnt                   cycles a read was held off by credit
module sram_rw_arb
  import vector_cache_pkg::*;
#(
  parameter int TAG_W         = SRAM_RSP_TAG_W,
  parameter int RSP_DEPTH     = 4,
  parameter int RD_STARVE_MAX = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_req_vld,
  output logic                        wr_req_rdy,
  input  sram_inst_cmd_t              wr_req_cmd,
  input  logic [SRAM_INST_DATA_W-1:0] wr_req_data,
  input  logic                        rd_req_vld,
  output logic                        rd_req_rdy,
  input  sram_inst_cmd_t              rd_req_cmd,
  input  logic [TAG_W-1:0]            rd_req_tag,
  output logic                        rsp_vld,
  input  logic                        rsp_rdy,
  output logic [SRAM_INST_DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]            rsp_tag,
  output logic                        sram_read_vld,
  output sram_inst_cmd_t              sram_read_cmd,
  output logic                        sram_write_vld,
  output sram_inst_cmd_t              sram_write_cmd,
  output logic [SRAM_INST_DATA_W-1:0] sram_wr_data,
  input  logic [SRAM_INST_DATA_W-1:0] sram_rd_data,
  output logic [15:0]                 perf_conflict_cnt,
  output logic [15:0]                 perf_stall_cnt
);

  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam int ST_W  = $clog2(RD_STARVE_MAX + 1);
  localparam int RSP_W = SRAM_INST_DATA_W + TAG_W;

  logic             inflight_q;
  logic [TAG_W-1:0] tag_q;
  logic [ST_W-1:0]  starve_q, starve_d;

  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full, fifo_empty;
  logic [RSP_W-1:0] fifo_head;
  logic             rsp_pop;

  logic rd_credit_ok, rd_cand, wr_cand, rd_win, wr_win;

  // Conservative credit: a pop in the same cycle is not credited until the next one.
  assign rd_credit_ok = (fifo_cnt + CNT_W'(inflight_q)) < CNT_W'(RSP_DEPTH);
  assign rd_cand      = rd_req_vld & rd_credit_ok;
  assign wr_cand      = wr_req_vld;

  // Write priority by default; a starved read wins once it has lost RD_STARVE_MAX times.
  assign rd_win = ~rst & rd_cand & (~wr_cand | (starve_q == ST_W'(RD_STARVE_MAX)));
  assign wr_win = ~rst & wr_cand & ~rd_win;

  assign wr_req_rdy = wr_win;
  assign rd_req_rdy = rd_win;

  assign sram_write_vld = wr_win;
  assign sram_write_cmd = wr_req_cmd;
  assign sram_wr_data   = wr_req_data;
  assign sram_read_vld  = rd_win;
  assign sram_read_cmd  = rd_req_cmd;

  always_comb begin
    starve_d = starve_q;
    if (!rd_cand || rd_win) begin
      starve_d = '0;
    end else if (wr_win && (starve_q != ST_W'(RD_STARVE_MAX))) begin
      starve_d = starve_q + ST_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      starve_q   <= '0;
    end else begin
      inflight_q <= rd_win;
      starve_q   <= starve_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_win) tag_q <= rd_req_tag;
  end

  // Read data arrives the cycle after the grant, alongside the registered tag.
  sram_rsp_fifo #(
    .W     (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i ({sram_rd_data, tag_q}),
    .pop_i       (rsp_pop),
    .pop_data_o  (fifo_head),
    .cnt_o       (fifo_cnt),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign rsp_vld  = ~fifo_empty;
  assign rsp_pop  = rsp_vld & rsp_rdy;
  assign rsp_data = fifo_head[RSP_W-1:TAG_W];
  assign rsp_tag  = fifo_head[TAG_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(inflight_q && fifo_full && !rsp_pop));
    end
  end

`ifdef SRAM_RW_ARB_PERF_EN
  logic [15:0] conflict_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= '0;
      stall_q    <= '0;
    end else begin
      if (rd_req_vld && wr_req_vld && (conflict_q != 16'hFFFF)) conflict_q <= conflict_q + 16'd1;
      if (rd_req_vld && !rd_credit_ok && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
    end
  end

  assign perf_conflict_cnt = conflict_q;
  assign perf_stall_cnt    = stall_q;
`else
  assign perf_conflict_cnt = '0;
  assign perf_stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_sram_rw_arb.sv
module tb_sram_rw_arb;
  import vector_cache_pkg::*;

  localparam int TAG_W = 4;
  localparam int DEPTH = 4;
  localparam int SMAX  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           wr_req_vld, wr_req_rdy;
  sram_inst_cmd_t wr_req_cmd;
  logic [31:0]    wr_req_data;
  logic           rd_req_vld, rd_req_rdy;
  sram_inst_cmd_t rd_req_cmd;
  logic [TAG_W-1:0] rd_req_tag;
  logic           rsp_vld, rsp_rdy;
  logic [31:0]    rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic           sram_read_vld, sram_write_vld;
  sram_inst_cmd_t sram_read_cmd, sram_write_cmd;
  logic [31:0]    sram_wr_data, sram_rd_data;
  logic [15:0]    perf_conflict_cnt, perf_stall_cnt;

  sram_rw_arb #(.TAG_W(TAG_W), .RSP_DEPTH(DEPTH), .RD_STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .wr_req_vld(wr_req_vld), .wr_req_rdy(wr_req_rdy), .wr_req_cmd(wr_req_cmd), .wr_req_data(wr_req_data),
    .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy), .rd_req_cmd(rd_req_cmd), .rd_req_tag(rd_req_tag),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .sram_read_vld(sram_read_vld), .sram_read_cmd(sram_read_cmd),
    .sram_write_vld(sram_write_vld), .sram_write_cmd(sram_write_cmd),
    .sram_wr_data(sram_wr_data), .sram_rd_data(sram_rd_data),
    .perf_conflict_cnt(perf_conflict_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_init(input int i);
    return (i == 16) ? 32'hA5A5_1234 : (32'h1000_0000 + 32'(i) * 32'h0001_0001);
  endfunction

  // SRAM model: word-wide, 1-cycle read latency, noise on rd_data when idle.
  logic [31:0] sram_mem [512];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) sram_mem[i] <= mem_init(i);
    end else if (sram_write_vld) begin
      sram_mem[sram_write_cmd.addr] <= sram_wr_data;
    end
    if (sram_read_vld) sram_rd_data <= sram_mem[sram_read_cmd.addr];
    else               sram_rd_data <= $urandom;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: memory contents, and the responses still owed in grant order.
  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    int               rc;   // earliest cycle the response may be presented
  } exp_t;
  exp_t        expq[$];
  logic [31:0] ref_mem [512];
  int  m_starve = 0, conf_cnt = 0, stall_cnt = 0;
  int  rd_grants = 0, last_rd_cyc = -1, last_wr_cyc = -1;
  int  rd_grant_cycles[$];
  bit  m_credit, m_rd, m_wr;

  always @(negedge clk) begin
    if (rst) begin
      chk("rdy_gated_in_rst", 64'({rd_req_rdy, wr_req_rdy, sram_read_vld, sram_write_vld}), 64'd0);
      expq.delete();
      m_starve = 0; conf_cnt = 0; stall_cnt = 0;
      for (int i = 0; i < 512; i++) ref_mem[i] = mem_init(i);
    end else begin
      m_credit = expq.size() < DEPTH;
      m_rd = rd_req_vld && m_credit && (!wr_req_vld || m_starve == SMAX);
      m_wr = wr_req_vld && !m_rd;
      chk("rd_req_rdy", 64'(rd_req_rdy), 64'(m_rd));
      chk("wr_req_rdy", 64'(wr_req_rdy), 64'(m_wr));
      chk("sram_read_vld", 64'(sram_read_vld), 64'(m_rd));
      chk("sram_write_vld", 64'(sram_write_vld), 64'(m_wr));
      chk("rd_wr_exclusive", 64'(sram_read_vld & sram_write_vld), 64'd0);
      if (m_rd) begin
        exp_t e;
        chk("sram_read_cmd", 64'(sram_read_cmd), 64'(rd_req_cmd));
        e.data = ref_mem[rd_req_cmd.addr];
        e.tag  = rd_req_tag;
        e.rc   = cyc + 2;
        expq.push_back(e);
        rd_grants++;
        last_rd_cyc = cyc;
        rd_grant_cycles.push_back(cyc);
      end
      if (m_wr) begin
        chk("sram_write_cmd", 64'(sram_write_cmd), 64'(wr_req_cmd));
        chk("sram_wr_data", 64'(sram_wr_data), 64'(wr_req_data));
        ref_mem[wr_req_cmd.addr] = wr_req_data;
        last_wr_cyc = cyc;
      end
      if (rd_req_vld && wr_req_vld) conf_cnt++;
      if (rd_req_vld && !m_credit)  stall_cnt++;
      if (!(rd_req_vld && m_credit) || m_rd) m_starve = 0;
      else if (m_wr && m_starve < SMAX)      m_starve++;
    end
  end

  // Response monitor: runs just after the grant model in each cycle.
  int               n_rsp = 0, last_rsp_cyc = -1;
  logic [31:0]      last_data;
  logic [TAG_W-1:0] last_tag;
  logic [TAG_W-1:0] rsp_tags[$];
  always begin
    bit ev;
    @(negedge clk);
    #1;
    if (!rst) begin
      ev = (expq.size() > 0) && (expq[0].rc <= cyc);
      chk("rsp_vld", 64'(rsp_vld), 64'(ev));
      if (rsp_vld && rsp_rdy && expq.size() > 0) begin
        chk("rsp_data", 64'(rsp_data), 64'(expq[0].data));
        chk("rsp_tag", 64'(rsp_tag), 64'(expq[0].tag));
        last_data = rsp_data;
        last_tag  = rsp_tag;
        last_rsp_cyc = cyc;
        rsp_tags.push_back(rsp_tag);
        n_rsp++;
        void'(expq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input bit v, input logic [8:0] a, input logic [TAG_W-1:0] t);
    rd_req_vld = v;
    rd_req_cmd = '{addr: a, byte_sel: 2'($urandom), mode: 1'($urandom)};
    rd_req_tag = t;
  endtask

  task automatic set_wr(input bit v, input logic [8:0] a, input logic [31:0] d);
    wr_req_vld  = v;
    wr_req_cmd  = '{addr: a, byte_sel: 2'($urandom), mode: 1'($urandom)};
    wr_req_data = d;
  endtask

  task automatic wait_rsp(input int target);
    for (int k = 0; k < 30 && n_rsp < target; k++) step();
    chk("rsp_wait_timeout", 64'(n_rsp >= target), 64'd1);
  endtask

  task automatic drain();
    rsp_rdy = 1'b1;
    for (int k = 0; k < 40 && expq.size() > 0; k++) step();
    chk("drain_timeout", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g0, t0, n0, s;
    logic [15:0] exp_c, exp_s;

    // Reset with both requests valid: ready must stay low.
    rst = 1'b1; rsp_rdy = 1'b1;
    set_rd(1'b1, 9'h010, 4'd1);
    set_wr(1'b1, 9'h011, 32'h1);
    step(); step();
    chk("reset_state", 64'({rsp_vld, rd_req_rdy, wr_req_rdy, sram_read_vld, sram_write_vld}), 64'd0);
    chk("reset_perf", 64'({perf_conflict_cnt, perf_stall_cnt}), 64'd0);
    set_rd(1'b0, 9'h0, 4'd0);
    set_wr(1'b0, 9'h0, 32'h0);
    step();
    rst = 1'b0;
    step();

    // Single read, latency 2.
    n0 = n_rsp;
    set_rd(1'b1, 9'h010, 4'd5);
    rd_req_cmd.byte_sel = 2'd2; rd_req_cmd.mode = 1'b0;
    step();
    set_rd(1'b0, 9'h0, 4'd0);
    wait_rsp(n0 + 1);
    chk("single_rd_data", 64'(last_data), 64'h0000_0000_A5A5_1234);
    chk("single_rd_tag", 64'(last_tag), 64'd5);
    chk("single_rd_latency", 64'(last_rsp_cyc - last_rd_cyc), 64'd2);

    // Same-address read and write: write first, read next cycle returns new data.
    n0 = n_rsp;
    set_rd(1'b1, 9'h020, 4'd3);
    set_wr(1'b1, 9'h020, 32'hDEAD_BEEF);
    step();
    set_wr(1'b0, 9'h0, 32'h0);
    step();
    set_rd(1'b0, 9'h0, 4'd0);
    chk("raw_order", 64'(last_rd_cyc - last_wr_cyc), 64'd1);
    wait_rsp(n0 + 1);
    chk("raw_data", 64'(last_data), 64'h0000_0000_DEAD_BEEF);
    step();

    // Continuous writes with a standing read: read every 4th cycle.
    g0 = rd_grants;
    s = cyc;
    for (int i = 0; i < 16; i++) begin
      set_rd(1'b1, 9'h030, 4'(i));
      set_wr(1'b1, 9'(9'h040 + i), $urandom);
      step();
    end
    set_rd(1'b0, 9'h0, 4'd0);
    set_wr(1'b0, 9'h0, 32'h0);
    chk("starve_grant_count", 64'(rd_grants - g0), 64'd4);
    if (rd_grants - g0 == 4) begin
      for (int k = 0; k < 4; k++)
        chk("starve_grant_cycle", 64'(rd_grant_cycles[g0 + k] - s), 64'(3 + 4 * k));
    end
    drain();

    // Credit limit with the consumer stalled.
    rsp_rdy = 1'b0;
    g0 = rd_grants;
    for (int i = 0; i < 10; i++) begin
      set_rd(1'b1, 9'(9'h050 + i), 4'(i));
      step();
    end
    #2;
    chk("credit_block_rdy", 64'(rd_req_rdy), 64'd0);
    chk("credit_grant_count", 64'(rd_grants - g0), 64'd4);
    t0 = rsp_tags.size();
    rsp_rdy = 1'b1;
    set_rd(1'b1, 9'h060, 4'd10);
    for (int k = 0; k < 20 && (rd_grants - g0) < 5; k++) step();
    set_rd(1'b0, 9'h0, 4'd0);
    chk("credit_resume", 64'(rd_grants - g0), 64'd5);
    drain();
    chk("credit_rsp_count", 64'(rsp_tags.size() - t0), 64'd5);
    if (rsp_tags.size() >= t0 + 5) begin
      for (int k = 0; k < 4; k++) chk("credit_rsp_order", 64'(rsp_tags[t0 + k]), 64'(k));
      chk("credit_rsp_resume_tag", 64'(rsp_tags[t0 + 4]), 64'd10);
    end

    // Reset right after a read grant with 2 entries held.
    rsp_rdy = 1'b0;
    set_rd(1'b1, 9'h001, 4'd1); step();
    set_rd(1'b1, 9'h002, 4'd2); step();
    set_rd(1'b0, 9'h0, 4'd0); step(); step(); step();
    set_rd(1'b1, 9'h070, 4'd7); step();
    set_rd(1'b0, 9'h0, 4'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #2;
    chk("rst_mid_rsp_vld", 64'(rsp_vld), 64'd0);
    n0 = n_rsp;
    rsp_rdy = 1'b1;
    step(); step();
    set_rd(1'b1, 9'h010, 4'd9); step();
    set_rd(1'b0, 9'h0, 4'd0);
    wait_rsp(n0 + 1);
    chk("rst_mid_new_tag", 64'(last_tag), 64'd9);
    chk("rst_mid_new_data", 64'(last_data), 64'h0000_0000_A5A5_1234);
    step(); step(); step();
    chk("rst_mid_no_stale", 64'(n_rsp - n0), 64'd1);

    // Perf counters: 7 conflict cycles, then 3 credit-stall cycles.
    rst = 1'b1; step(); rst = 1'b0; step();
    rsp_rdy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_rd(1'b1, 9'h080, 4'(i));
      set_wr(1'b1, 9'(9'h090 + i), $urandom);
      step();
    end
    set_rd(1'b0, 9'h0, 4'd0);
    set_wr(1'b0, 9'h0, 32'h0);
    drain();
    rsp_rdy = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_rd(1'b1, 9'(9'h0A0 + i), 4'(i));
      step();
    end
    set_rd(1'b0, 9'h0, 4'd0);
    #2;
`ifdef SRAM_RW_ARB_PERF_EN
    exp_c = 16'd7; exp_s = 16'd3;
`else
    exp_c = 16'd0; exp_s = 16'd0;
`endif
    chk("perf_conflict_dir", 64'(perf_conflict_cnt), 64'(exp_c));
    chk("perf_stall_dir", 64'(perf_stall_cnt), 64'(exp_s));
    drain();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      set_rd(1'($urandom_range(0, 99) < 55), 9'($urandom_range(0, 7)), 4'($urandom));
      set_wr(1'($urandom_range(0, 99) < 50), 9'($urandom_range(0, 7)), $urandom);
      rsp_rdy = ($urandom_range(0, 99) < 65);
      step();
    end
    rst = 1'b0;
    set_rd(1'b0, 9'h0, 4'd0);
    set_wr(1'b0, 9'h0, 32'h0);
    drain();
    step();
    #2;
`ifdef SRAM_RW_ARB_PERF_EN
    exp_c = (conf_cnt > 65535) ? 16'hFFFF : 16'(conf_cnt);
    exp_s = (stall_cnt > 65535) ? 16'hFFFF : 16'(stall_cnt);
`else
    exp_c = 16'd0; exp_s = 16'd0;
`endif
    chk("perf_conflict_rand", 64'(perf_conflict_cnt), 64'(exp_c));
    chk("perf_stall_rand", 64'(perf_stall_cnt), 64'(exp_s));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_rw_arb.md
Name: sram_rw_arb

Overview:
- Single-port access controller that sits in front of one sram_inst.
- Arbitrates an independent write-request channel and read-request channel onto the SRAM's read/write command ports, so read_vld and write_vld are never both high.
- Captures the 1-cycle-latency SRAM read data with its tag into a response FIFO.
- Returns responses over a valid/ready channel, using credits to bound outstanding reads.

Parameters:
- TAG_W, 4, width of the read-request tag returned with each response.
- RSP_DEPTH, 4, response FIFO entries; power of two, at least 2.
- RD_STARVE_MAX, 3, consecutive lost arbitration cycles after which a pending read beats a pending write.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- wr_req_vld  in  1  write request valid.
- wr_req_rdy  out  1  write request accepted this cycle.
- wr_req_cmd  in  sram_inst_cmd_t  write addr[8:0], byte_sel[1:0], mode.
- wr_req_data  in  32  write data.
- rd_req_vld  in  1  read request valid.
- rd_req_rdy  out  1  read request accepted this cycle.
- rd_req_cmd  in  sram_inst_cmd_t  read addr, byte_sel, mode.
- rd_req_tag  in  TAG_W  requester tag.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response consumer ready.
- rsp_data  out  32  read data.
- rsp_tag  out  TAG_W  tag of the response.
- sram_read_vld  out  1  to sram_inst read_vld.
- sram_read_cmd  out  sram_inst_cmd_t  to sram_inst read_cmd.
- sram_write_vld  out  1  to sram_inst write_vld.
- sram_write_cmd  out  sram_inst_cmd_t  to sram_inst write_cmd.
- sram_wr_data  out  32  to sram_inst wr_data.
- sram_rd_data  in  32  from sram_inst rd_data; valid 1 cycle after sram_read_vld.
- perf_conflict_cnt  out  16  cycles where read and write both requested.
- perf_stall_cnt  out  16  cycles where a read was blocked by lack of credit.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst). Synchronous to clk; rst sampled only at the clk edge.

Credit:
- rd_credit_ok = (fifo_cnt + inflight) < RSP_DEPTH.
- inflight is a 1-bit register set in the cycle after a read grant.
- No lookahead on a same-cycle pop; the check is conservative.

Arbitration (combinational grant, one grant per cycle at most):
- rd_cand = rd_req_vld & rd_credit_ok; wr_cand = wr_req_vld.
- Default is write priority. A read wins if rd_cand & (!wr_cand | starve_cnt == RD_STARVE_MAX).
- wr_req_rdy = wr_cand & !rd_win; rd_req_rdy = rd_win.

SRAM drive:
- sram_write_vld = wr grant, with sram_write_cmd/sram_wr_data passed through.
- sram_read_vld = rd grant, with sram_read_cmd = rd_req_cmd.
- Cmd outputs are don't-care when not valid; drive the request fields.

Starvation counter:
- starve_cnt (width clog2(RD_STARVE_MAX+1)) increments, saturating, when rd_cand and a write is granted.
- Clears on any read grant, or when rd_cand is low.

Response path:
- On a read grant at cycle T, the tag is registered with inflight.
- At T+1, sram_rd_data and the tag are pushed into the FIFO.
- rsp_vld is asserted from the FIFO head at T+2 at the earliest (latency 2).
- A pop occurs on rsp_vld & rsp_rdy. A simultaneous push and pop keeps fifo_cnt unchanged.
- The FIFO cannot overflow by credit construction. An overflow is an assertion failure in simulation.

Ordering and hazards:
- Same-address read and write in the same cycle: the write is granted first. The read is granted later and returns the new data.
- Responses are returned in grant order.

Reset values and reset mid-operation:
- Reset values: rsp_vld=0, wr_req_rdy=0, rd_req_rdy=0, sram_read_vld=0, sram_write_vld=0, perf counters=0, fifo_cnt=0, inflight=0, starve_cnt=0.
- Reset asserted mid-operation drops any inflight read and empties the FIFO. The returned sram_rd_data is ignored.
- While rst is high, no grant is issued. The req_rdy outputs are forced 0 by gating with rst.

Optional Feature:
- Macro: SRAM_RW_ARB_PERF_EN.
- When defined:
  - perf_conflict_cnt increments when rd_req_vld & wr_req_vld.
  - perf_stall_cnt increments when rd_req_vld & !rd_credit_ok.
  - Both counters are 16-bit, saturating, and cleared by rst.
- When undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- vector_cache_pkg (shared) already holds sram_inst_cmd_t.
- Add to vector_cache_pkg: SRAM_INST_ADDR_W=9, SRAM_INST_DATA_W=32, and a typedef sram_rsp_t {data[31:0], tag}, with the tag sized by a package constant SRAM_RSP_TAG_W.
- Sub-module sram_rsp_fifo: synchronous FIFO, parameterised depth, push/pop, cnt, full/empty. Reusable elsewhere.
- The arbiter, credit and starvation logic stay in sram_rw_arb.

Test Plan:
- Single read of addr 0x010, byte_sel 2, mode 0, tag 5; SRAM model returns 0xA5A5_1234 -> rsp_vld at T+2, rsp_data 0xA5A5_1234, rsp_tag 5.
- Read and write both pending to addr 0x020 with wr_data 0xDEAD_BEEF -> write granted first, read granted next cycle. The response carries 0xDEAD_BEEF, and sram_read_vld & sram_write_vld are never both 1.
- Continuous write stream plus a constant read request, RD_STARVE_MAX=3 -> read granted exactly every 4th cycle; starve_cnt returns to 0 after each read grant.
- rsp_rdy held 0 and 10 back-to-back reads offered, RSP_DEPTH=4 -> exactly 4 reads granted, then rd_req_rdy=0. Raising rsp_rdy drains the 4 responses in order, then granting resumes.
- rst pulsed 1 cycle in the cycle after a read grant with 2 FIFO entries held -> rsp_vld=0 next cycle, FIFO empty, the in-flight response never appears, and a new read afterwards returns normally.
- With SRAM_RW_ARB_PERF_EN, 7 conflict cycles and 3 credit-stall cycles -> perf_conflict_cnt=7, perf_stall_cnt=3. Without the macro both stay 0.
